// File: rtl/mem_exec_unit.sv
// Load/store execution unit: takes one memory op at a time from the load/store
// queue, runs a single valid/ready request to data memory, and writes load
// results back on the CDB. Stores retire once the memory accepts the request.
// Ports: clk/rst, flush, execute_pkt_* (issued op), alu_rdy/cache_stall (issue
// side), dmem_* (memory request/response), wb_pkt_* (CDB), err_misalign.
module mem_exec_unit #(
  parameter int DMEM_ADDR_WIDTH = 32,
  parameter int TAG_WIDTH       = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       execute_pkt_is_valid,
  input  logic                       execute_pkt_is_store,
  input  logic [2:0]                 execute_pkt_funct3,
  input  logic [DMEM_ADDR_WIDTH-1:0] execute_pkt_addr,
  input  logic [31:0]                execute_pkt_store_data,
  input  logic [TAG_WIDTH-1:0]       execute_pkt_dest_tag,
  output logic                       alu_rdy,
  output logic                       cache_stall,
  output logic                       dmem_req_val,
  input  logic                       dmem_req_rdy,
  output logic                       dmem_we,
  output logic [DMEM_ADDR_WIDTH-1:0] dmem_addr,
  output logic [31:0]                dmem_wdata,
  output logic [3:0]                 dmem_wstrb,
  input  logic                       dmem_resp_val,
  input  logic [31:0]                dmem_rdata,
  output logic                       wb_pkt_valid,
  output logic [TAG_WIDTH-1:0]       wb_pkt_tag,
  output logic [31:0]                wb_pkt_result,
  output logic                       err_misalign
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, WB, DRAIN} state_t;

  state_t                       state_q, state_d;
  logic                         is_store_q, is_store_d;
  logic [2:0]                   funct3_q, funct3_d;
  logic [1:0]                   lane_q, lane_d;
  logic [TAG_WIDTH-1:0]         tag_q, tag_d;
  logic [DMEM_ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [31:0]                  wdata_q, wdata_d;
  logic [3:0]                   wstrb_q, wstrb_d;
  logic [31:0]                  result_q, result_d;

  logic                         accept;
  logic                         misalign;
  logic [7:0]                   ld_byte;
  logic [15:0]                  ld_half;
  logic [31:0]                  ld_result;

  // A flush in IDLE blocks acceptance: the presented packet is speculative.
  always_comb begin
    accept   = (state_q == IDLE) && execute_pkt_is_valid && !flush;
    misalign = ((execute_pkt_funct3[1:0] == 2'b01) && execute_pkt_addr[0]) ||
               (execute_pkt_funct3[1] && (execute_pkt_addr[1:0] != 2'b00));
  end

  // Load result extraction from the returned word, using the latched lane.
  always_comb begin
    ld_byte = dmem_rdata[7:0];
    case (lane_q)
      2'd0: ld_byte = dmem_rdata[7:0];
      2'd1: ld_byte = dmem_rdata[15:8];
      2'd2: ld_byte = dmem_rdata[23:16];
      default: ld_byte = dmem_rdata[31:24];
    endcase
    ld_half = lane_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (funct3_q)
      3'b000:  ld_result = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_result = {24'd0, ld_byte};
      3'b001:  ld_result = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_result = {16'd0, ld_half};
      default: ld_result = dmem_rdata;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    is_store_d = is_store_q;
    funct3_d   = funct3_q;
    lane_d     = lane_q;
    tag_d      = tag_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    result_d   = result_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          is_store_d = execute_pkt_is_store;
          funct3_d   = execute_pkt_funct3;
          lane_d     = execute_pkt_addr[1:0];
          tag_d      = execute_pkt_dest_tag;
          addr_d     = {execute_pkt_addr[DMEM_ADDR_WIDTH-1:2], 2'b00};
          wdata_d    = 32'd0;
          wstrb_d    = 4'h0;
          if (execute_pkt_is_store) begin
            case (execute_pkt_funct3[1:0])
              2'b00: begin
                wstrb_d = 4'b0001 << execute_pkt_addr[1:0];
                wdata_d = {4{execute_pkt_store_data[7:0]}};
              end
              2'b01: begin
                wstrb_d = 4'b0011 << execute_pkt_addr[1:0];
                wdata_d = {2{execute_pkt_store_data[15:0]}};
              end
              default: begin
                wstrb_d = 4'hF;
                wdata_d = execute_pkt_store_data;
              end
            endcase
          end
          // Misaligned ops never reach memory; a load still owes the CDB
          // a (zero) result so its consumer is released.
          if (misalign) begin
            if (!execute_pkt_is_store) begin
              result_d = 32'd0;
              state_d  = WB;
            end
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (dmem_req_rdy) begin
          if (is_store_q)  state_d = IDLE;
          else if (flush)  state_d = DRAIN;  // response is coming; must be absorbed
          else             state_d = WAIT;
        end else if (flush && !is_store_q) begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (dmem_resp_val) begin
          result_d = ld_result;
          state_d  = flush ? IDLE : WB;
        end else if (flush) begin
          state_d = DRAIN;
        end
      end
      WB: begin
        state_d = IDLE;
      end
      DRAIN: begin
        if (dmem_resp_val) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      is_store_q <= 1'b0;
      funct3_q   <= 3'd0;
      lane_q     <= 2'd0;
      tag_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= 32'd0;
      wstrb_q    <= 4'h0;
      result_q   <= 32'd0;
    end else begin
      state_q    <= state_d;
      is_store_q <= is_store_d;
      funct3_q   <= funct3_d;
      lane_q     <= lane_d;
      tag_q      <= tag_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      result_q   <= result_d;
    end
  end

  // Outputs are forced to their idle values while rst is high, so the
  // reset cycle itself already looks idle to neighbours.
  always_comb begin
    alu_rdy       = rst || (state_q == IDLE);
    cache_stall   = !rst && ((state_q == REQ) || (state_q == WAIT) || (state_q == DRAIN));
    dmem_req_val  = !rst && (state_q == REQ);
    dmem_we       = dmem_req_val && is_store_q;
    dmem_addr     = rst ? '0 : addr_q;
    dmem_wdata    = rst ? 32'd0 : wdata_q;
    dmem_wstrb    = rst ? 4'h0 : wstrb_q;
    wb_pkt_valid  = !rst && (state_q == WB) && !flush;
    wb_pkt_tag    = wb_pkt_valid ? tag_q : '0;
    wb_pkt_result = wb_pkt_valid ? result_q : 32'd0;
    err_misalign  = !rst && accept && misalign;
  end

endmodule

// File: tb/tb_mem_exec_unit.sv
module tb_mem_exec_unit;

  typedef struct {
    logic [5:0]  tag;
    logic [31:0] result;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        ep_valid;
  logic        ep_store;
  logic [2:0]  ep_funct3;
  logic [31:0] ep_addr;
  logic [31:0] ep_data;
  logic [5:0]  ep_tag;
  logic        alu_rdy;
  logic        cache_stall;
  logic        dmem_req_val;
  logic        req_rdy;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        resp_val;
  logic [31:0] rdata;
  logic        wb_pkt_valid;
  logic [5:0]  wb_pkt_tag;
  logic [31:0] wb_pkt_result;
  logic        err_misalign;

  int   tests_run = 0;
  int   tests_failed = 0;
  exp_t exp_q[$];

  mem_exec_unit #(.DMEM_ADDR_WIDTH(32), .TAG_WIDTH(6)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .execute_pkt_is_valid(ep_valid), .execute_pkt_is_store(ep_store),
    .execute_pkt_funct3(ep_funct3), .execute_pkt_addr(ep_addr),
    .execute_pkt_store_data(ep_data), .execute_pkt_dest_tag(ep_tag),
    .alu_rdy(alu_rdy), .cache_stall(cache_stall),
    .dmem_req_val(dmem_req_val), .dmem_req_rdy(req_rdy), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_resp_val(resp_val), .dmem_rdata(rdata),
    .wb_pkt_valid(wb_pkt_valid), .wb_pkt_tag(wb_pkt_tag), .wb_pkt_result(wb_pkt_result),
    .err_misalign(err_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference load extraction, written independently from the RTL.
  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [1:0] lane,
                                           input logic [31:0] w);
    logic [31:0] sh;
    logic [31:0] r;
    sh = w >> (lane * 8);
    case (f3)
      3'b000:  r = {{24{sh[7]}}, sh[7:0]};
      3'b100:  r = {24'd0, sh[7:0]};
      3'b001:  r = {{16{sh[15]}}, sh[15:0]};
      3'b101:  r = {16'd0, sh[15:0]};
      default: r = w;
    endcase
    return r;
  endfunction

  task automatic run_load(input logic [2:0] f3, input logic [31:0] a, input logic [5:0] tag,
                          input logic [31:0] rd, input logic [31:0] exp_res, input int rdy_delay);
    exp_t e;
    int   waited;
    ep_valid = 1'b1; ep_store = 1'b0; ep_funct3 = f3; ep_addr = a; ep_tag = tag; req_rdy = 1'b0;
    #1;
    tests_run++;
    if (alu_rdy !== 1'b1 || err_misalign !== 1'b0) begin
      tests_failed++;
      $display("FAIL load_accept: alu_rdy=%b err=%b required 1/0", alu_rdy, err_misalign);
    end
    e.tag = tag; e.result = exp_res; exp_q.push_back(e);
    cyc();
    ep_valid = 1'b0;
    for (int i = 0; i < rdy_delay; i++) cyc();
    req_rdy = 1'b1;
    #1;
    tests_run++;
    if (dmem_req_val !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== {a[31:2], 2'b00}) begin
      tests_failed++;
      $display("FAIL load_req: val=%b we=%b addr=%h required 1/0/%h",
               dmem_req_val, dmem_we, dmem_addr, {a[31:2], 2'b00});
    end
    cyc();
    req_rdy = 1'b0; resp_val = 1'b1; rdata = rd;
    cyc();
    resp_val = 1'b0;
    #1;
    waited = 0;
    while (wb_pkt_valid !== 1'b1 && waited < 20) begin
      cyc();
      waited++;
    end
    tests_run++;
    if (wb_pkt_valid !== 1'b1 || waited != 0 || exp_q.size() == 0) begin
      tests_failed++;
      $display("FAIL load_wb_timing: valid=%b after %0d extra cycles, required valid at once",
               wb_pkt_valid, waited);
    end else begin
      e = exp_q.pop_front();
      if (wb_pkt_tag !== e.tag || wb_pkt_result !== e.result) begin
        tests_failed++;
        $display("FAIL load_wb_data: tag=%0d result=%h required tag=%0d result=%h",
                 wb_pkt_tag, wb_pkt_result, e.tag, e.result);
      end
    end
    cyc();
    #1;
    tests_run++;
    if (wb_pkt_valid !== 1'b0 || alu_rdy !== 1'b1) begin
      tests_failed++;
      $display("FAIL load_done: wb_valid=%b alu_rdy=%b required 0/1", wb_pkt_valid, alu_rdy);
    end
  endtask

  task automatic run_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] exp_strb, input logic [31:0] exp_wdata, input int rdy_delay);
    int held;
    int bad;
    ep_valid = 1'b1; ep_store = 1'b1; ep_funct3 = f3; ep_addr = a; ep_data = d; ep_tag = 6'd0;
    req_rdy = 1'b0;
    cyc();
    ep_valid = 1'b0;
    held = 0; bad = 0;
    for (int i = 0; i <= rdy_delay; i++) begin
      req_rdy = (i == rdy_delay);
      #1;
      if (dmem_req_val === 1'b1) held++;
      if (dmem_we !== 1'b1 || dmem_wstrb !== exp_strb || dmem_wdata !== exp_wdata ||
          dmem_addr !== {a[31:2], 2'b00} || wb_pkt_valid !== 1'b0) bad++;
      cyc();
    end
    req_rdy = 1'b0;
    #1;
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL store_fields: addr=%h we=%b wstrb=%b wdata=%h required %h/1/%b/%h",
               dmem_addr, dmem_we, dmem_wstrb, dmem_wdata, {a[31:2], 2'b00}, exp_strb, exp_wdata);
    end
    tests_run++;
    if (held != rdy_delay + 1) begin
      tests_failed++;
      $display("FAIL store_req_held: %0d cycles required %0d", held, rdy_delay + 1);
    end
    tests_run++;
    if (alu_rdy !== 1'b1 || dmem_req_val !== 1'b0 || wb_pkt_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL store_done: alu_rdy=%b req_val=%b wb=%b required 1/0/0",
               alu_rdy, dmem_req_val, wb_pkt_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    tests_run++;
    if (alu_rdy !== 1'b1 || cache_stall !== 1'b0 || dmem_req_val !== 1'b0 || dmem_we !== 1'b0 ||
        err_misalign !== 1'b0 || wb_pkt_valid !== 1'b0 || dmem_addr !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_during: rdy=%b stall=%b req=%b we=%b err=%b wb=%b addr=%h",
               alu_rdy, cache_stall, dmem_req_val, dmem_we, err_misalign, wb_pkt_valid, dmem_addr);
    end
    cyc(); cyc();
    rst = 1'b0;
    #1;
    tests_run++;
    if (alu_rdy !== 1'b1 || cache_stall !== 1'b0 || dmem_req_val !== 1'b0 || dmem_wdata !== 32'd0 ||
        dmem_wstrb !== 4'h0 || dmem_addr !== 32'd0 || wb_pkt_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_after: rdy=%b stall=%b req=%b wdata=%h wstrb=%b addr=%h",
               alu_rdy, cache_stall, dmem_req_val, dmem_wdata, dmem_wstrb, dmem_addr);
    end
    cyc();
  endtask

  task automatic test_lw();
    run_load(3'b010, 32'h100, 6'd5, 32'hDEADBEEF, 32'hDEADBEEF, 0);
  endtask

  task automatic test_lb_lbu();
    run_load(3'b000, 32'h103, 6'd7, 32'h80FFFFFF, 32'hFFFFFF80, 0);
    run_load(3'b100, 32'h103, 6'd8, 32'h80FFFFFF, 32'h00000080, 1);
    run_load(3'b001, 32'h106, 6'd9, 32'h9ABC1234, 32'hFFFF9ABC, 0);
    run_load(3'b101, 32'h106, 6'd10, 32'h9ABC1234, 32'h00009ABC, 0);
  endtask

  task automatic test_store_lanes();
    run_store(3'b001, 32'h202, 32'h00001234, 4'b1100, 32'h12341234, 3);
    run_store(3'b000, 32'h301, 32'h000000AB, 4'b0010, 32'hABABABAB, 0);
    run_store(3'b000, 32'h303, 32'h0000005A, 4'b1000, 32'h5A5A5A5A, 1);
    run_store(3'b010, 32'h404, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D, 0);
  endtask

  task automatic test_misalign();
    exp_t e;
    ep_valid = 1'b1; ep_store = 1'b0; ep_funct3 = 3'b010; ep_addr = 32'h101; ep_tag = 6'd9;
    #1;
    tests_run++;
    if (err_misalign !== 1'b1) begin
      tests_failed++;
      $display("FAIL misalign_lw_err: err=%b required 1", err_misalign);
    end
    e.tag = 6'd9; e.result = 32'd0; exp_q.push_back(e);
    cyc();
    ep_valid = 1'b0;
    #1;
    tests_run++;
    if (err_misalign !== 1'b0 || dmem_req_val !== 1'b0) begin
      tests_failed++;
      $display("FAIL misalign_lw_noreq: err=%b req_val=%b required 0/0", err_misalign, dmem_req_val);
    end
    tests_run++;
    if (wb_pkt_valid !== 1'b1 || exp_q.size() == 0) begin
      tests_failed++;
      $display("FAIL misalign_lw_wb: valid=%b required 1", wb_pkt_valid);
    end else begin
      e = exp_q.pop_front();
      if (wb_pkt_tag !== e.tag || wb_pkt_result !== e.result) begin
        tests_failed++;
        $display("FAIL misalign_lw_data: tag=%0d result=%h required %0d/%h",
                 wb_pkt_tag, wb_pkt_result, e.tag, e.result);
      end
    end
    cyc();
    ep_valid = 1'b1; ep_store = 1'b1; ep_funct3 = 3'b001; ep_addr = 32'h203; ep_data = 32'h55;
    #1;
    tests_run++;
    if (err_misalign !== 1'b1 || alu_rdy !== 1'b1) begin
      tests_failed++;
      $display("FAIL misalign_sh_err: err=%b rdy=%b required 1/1", err_misalign, alu_rdy);
    end
    cyc();
    ep_valid = 1'b0;
    #1;
    tests_run++;
    if (alu_rdy !== 1'b1 || dmem_req_val !== 1'b0 || wb_pkt_valid !== 1'b0 || err_misalign !== 1'b0) begin
      tests_failed++;
      $display("FAIL misalign_sh_idle: rdy=%b req=%b wb=%b err=%b required 1/0/0/0",
               alu_rdy, dmem_req_val, wb_pkt_valid, err_misalign);
    end
    cyc();
  endtask

  task automatic test_flush_wait();
    int wb_seen;
    wb_seen = 0;
    ep_valid = 1'b1; ep_store = 1'b0; ep_funct3 = 3'b010; ep_addr = 32'h40; ep_tag = 6'd3;
    req_rdy = 1'b1;
    cyc();
    ep_valid = 1'b0;            // REQ, handshake now
    cyc();
    req_rdy = 1'b0; flush = 1'b1;   // WAIT with flush
    cyc();
    flush = 1'b0;
    #1;
    tests_run++;
    if (cache_stall !== 1'b1 || alu_rdy !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_drain_state: stall=%b rdy=%b required 1/0", cache_stall, alu_rdy);
    end
    cyc();
    resp_val = 1'b1; rdata = 32'h11111111;
    #1;
    if (wb_pkt_valid === 1'b1) wb_seen++;
    cyc();
    resp_val = 1'b0;
    #1;
    if (wb_pkt_valid === 1'b1) wb_seen++;
    tests_run++;
    if (alu_rdy !== 1'b1 || cache_stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_drain_exit: rdy=%b stall=%b required 1/0", alu_rdy, cache_stall);
    end
    cyc();
    #1;
    if (wb_pkt_valid === 1'b1) wb_seen++;
    tests_run++;
    if (wb_seen != 0) begin
      tests_failed++;
      $display("FAIL flush_drain_nowb: %0d writebacks required 0", wb_seen);
    end
  endtask

  task automatic test_flush_misc();
    // flush in IDLE: packet not accepted
    ep_valid = 1'b1; ep_store = 1'b0; ep_funct3 = 3'b010; ep_addr = 32'h80; ep_tag = 6'd4;
    flush = 1'b1;
    cyc();
    ep_valid = 1'b0; flush = 1'b0;
    #1;
    tests_run++;
    if (alu_rdy !== 1'b1 || dmem_req_val !== 1'b0 || cache_stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_idle: rdy=%b req=%b stall=%b required 1/0/0", alu_rdy, dmem_req_val, cache_stall);
    end
    // flush in REQ before handshake: abandon
    ep_valid = 1'b1;
    cyc();
    ep_valid = 1'b0; req_rdy = 1'b0; flush = 1'b1;
    cyc();
    flush = 1'b0;
    #1;
    tests_run++;
    if (alu_rdy !== 1'b1 || dmem_req_val !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_req: rdy=%b req=%b required 1/0", alu_rdy, dmem_req_val);
    end
    // flush during WB: result suppressed
    ep_valid = 1'b1;
    cyc();
    ep_valid = 1'b0; req_rdy = 1'b1;
    cyc();
    req_rdy = 1'b0; resp_val = 1'b1; rdata = 32'h22;
    cyc();
    resp_val = 1'b0; flush = 1'b1;
    #1;
    tests_run++;
    if (wb_pkt_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_wb: valid=%b required 0", wb_pkt_valid);
    end
    cyc();
    flush = 1'b0;
    #1;
    tests_run++;
    if (alu_rdy !== 1'b1 || wb_pkt_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_wb_exit: rdy=%b wb=%b required 1/0", alu_rdy, wb_pkt_valid);
    end
    cyc();
  endtask

  task automatic test_rst_wait();
    ep_valid = 1'b1; ep_store = 1'b0; ep_funct3 = 3'b010; ep_addr = 32'h500; ep_tag = 6'd12;
    req_rdy = 1'b1;
    cyc();
    ep_valid = 1'b0;
    cyc();
    req_rdy = 1'b0; rst = 1'b1;      // in WAIT
    #1;
    tests_run++;
    if (alu_rdy !== 1'b1 || cache_stall !== 1'b0 || dmem_req_val !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_wait_during: rdy=%b stall=%b req=%b required 1/0/0", alu_rdy, cache_stall, dmem_req_val);
    end
    cyc();
    rst = 1'b0;
    #1;
    tests_run++;
    if (alu_rdy !== 1'b1 || cache_stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_wait_after: rdy=%b stall=%b required 1/0", alu_rdy, cache_stall);
    end
    resp_val = 1'b1; rdata = 32'h33;
    cyc();
    resp_val = 1'b0;
    #1;
    tests_run++;
    if (wb_pkt_valid !== 1'b0 || alu_rdy !== 1'b1 || cache_stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_late_resp: wb=%b rdy=%b stall=%b required 0/1/0", wb_pkt_valid, alu_rdy, cache_stall);
    end
    cyc();
  endtask

  task automatic test_back_to_back();
    logic [2:0]  f3s [5];
    logic [2:0]  f3;
    logic [1:0]  lane;
    logic [31:0] w;
    logic [31:0] a;
    f3s[0] = 3'b000; f3s[1] = 3'b001; f3s[2] = 3'b010; f3s[3] = 3'b100; f3s[4] = 3'b101;
    for (int n = 0; n < 10; n++) begin
      f3   = f3s[$urandom_range(0, 4)];
      lane = 2'($urandom_range(0, 3));
      if (f3[0]) lane[0] = 1'b0;
      if (f3[1]) lane = 2'd0;
      w = $urandom;
      a = {18'd0, 12'($urandom), lane};
      run_load(f3, a, 6'(n + 20), w, exp_load(f3, lane, w), $urandom_range(0, 2));
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: %0d entries left required 0", exp_q.size());
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; ep_valid = 1'b0; ep_store = 1'b0; ep_funct3 = 3'd0;
    ep_addr = 32'd0; ep_data = 32'd0; ep_tag = 6'd0; req_rdy = 1'b0; resp_val = 1'b0; rdata = 32'd0;
    test_reset();
    test_lw();
    test_lb_lbu();
    test_store_lanes();
    test_misalign();
    test_flush_wait();
    test_flush_misc();
    test_rst_wait();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mem_exec_unit.md
MEM_EXEC_UNIT -- requirements
Module: mem_exec_unit

Interface
REQ-001 Parameter: DMEM_ADDR_WIDTH, 32, data-memory byte-address width.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 flush  input  1  pipeline flush; squashes speculative loads.
REQ-005 execute_pkt  input  instruction_t  memory op issued by the load/store queue.
  - Fields used: is_valid, is_store, funct3, addr (effective address from AGU), store_data, dest_tag.
REQ-006 alu_rdy  output  1  unit can accept execute_pkt this cycle.
REQ-007 cache_stall  output  1  access in flight; issuing queue holds state.
REQ-008 dmem_req_val  output  1  memory request valid.
REQ-009 dmem_req_rdy  input  1  memory accepts the request.
REQ-010 dmem_we  output  1  request is a store.
REQ-011 dmem_addr  output  DMEM_ADDR_WIDTH  word-aligned address (bits[1:0]=0).
REQ-012 dmem_wdata  output  32  store data, lane-shifted.
REQ-013 dmem_wstrb  output  4  byte enables.
REQ-014 dmem_resp_val  input  1  load data valid.
REQ-015 dmem_rdata  input  32  load word.
REQ-016 wb_pkt  output  writeback_packet_t  load result to CDB; valid, tag, result.
REQ-017 err_misalign  output  1  one-cycle pulse on a misaligned op.

Function
REQ-018 FSM states: IDLE, REQ, WAIT, WB, DRAIN.
REQ-019 Handshake and alu_rdy:
  - alu_rdy=1 only in IDLE.
  - Accept when alu_rdy && execute_pkt.is_valid: latch the packet, go to REQ next cycle.
REQ-020 cache_stall=1 in REQ, WAIT, DRAIN; 0 otherwise.
REQ-021 REQ state:
  - Hold dmem_req_val=1 and stable address/data/strobe until dmem_req_rdy=1.
  - On handshake, a store goes to IDLE and a load goes to WAIT.
REQ-022 WAIT: on dmem_resp_val, capture the extracted result and go to WB.
REQ-023 WB:
  - Drive wb_pkt.valid=1 for exactly one cycle, with tag=latched dest_tag.
  - Go to IDLE; wb_pkt.valid=0 in all other states.
REQ-024 Load extraction (funct3), lane = addr[1:0]:
  - LB/LBU: byte at lane*8, sign-/zero-extended.
  - LH/LHU: half at addr[1]*16, sign-/zero-extended.
  - LW: full word.
REQ-025 Store strobes:
  - SB: wstrb=4'b0001<<addr[1:0], wdata = byte replicated in all lanes.
  - SH: wstrb=4'b0011<<addr[1:0], wdata = half replicated in both halves.
  - SW: wstrb=4'hF, wdata = store_data.
REQ-026 Misalignment:
  - Misaligned = halfword with addr[0]=1, or word with addr[1:0]!=0.
  - On acceptance of a misaligned op: no memory request, err_misalign pulses in the acceptance cycle.
  - Load: goes to WB with result=0.
  - Store: returns to IDLE.
REQ-027 Best-case load latency: accept cycle N, req N+1 (req_rdy=1), resp N+2, wb_pkt.valid N+3.
REQ-028 Best-case store: accept N, req N+1, alu_rdy=1 again at N+2.
REQ-029 flush behaviour per state:
  - IDLE: no effect, and a packet presented that cycle is not accepted.
  - REQ with load, handshake not yet done: go to IDLE, no request issued.
  - REQ with load, handshake in the same cycle: go to DRAIN.
  - WAIT: go to DRAIN.
  - WB: wb_pkt suppressed (valid=0), go to IDLE.
  - Stores: unaffected, since they are already committed.
REQ-030 DRAIN: wait for dmem_resp_val, discard the data, go to IDLE; no wb_pkt.
REQ-031 flush and dmem_resp_val in the same WAIT cycle: discard the response, go to IDLE.

Reset
REQ-032 rst forces IDLE, abandoning any in-flight access with no response tracking.
REQ-033 Output values during and after rst:
  - 1: alu_rdy.
  - 0: dmem_req_val, dmem_we, cache_stall, err_misalign, wb_pkt.
  - dmem_addr/wdata/wstrb = 0.
REQ-034 rst has priority over flush and all handshakes.

Verification
REQ-035 LW addr=0x100, tag=5, req_rdy=1, rdata=0xDEADBEEF one cycle later -> dmem_addr=0x100; wb_pkt{valid=1, tag=5, result=0xDEADBEEF} three cycles after accept.
REQ-036 LB addr=0x103, rdata=0x80FFFFFF -> result=0xFFFFFF80; LBU same -> 0x00000080.
REQ-037 SH addr=0x202, store_data=0x1234, req_rdy low for 3 cycles -> req_val held 4 cycles, wstrb=4'b1100, wdata=0x12341234, no wb_pkt.
REQ-038 LW addr=0x101 -> err_misalign pulse, no dmem_req_val, wb_pkt result=0.
REQ-039 LW accepted, flush in WAIT, resp two cycles later -> no wb_pkt, alu_rdy=1 the cycle after resp.
REQ-040 rst asserted in WAIT -> next cycle IDLE, alu_rdy=1, cache_stall=0; a late dmem_resp_val is ignored.
